huff_pair_decoder: RTL and testbench

Parametrised serial Huffman pair decoder for MP3 big-values regions. It consumes one bitstream bit per cycle and resolves a codeword through an external per-table codebook port. It then collects escape (linbits) and sign bits and emits a signed (x, y) pair over a valid/ready handshake. This block replaces the per-table decoders: one instance serves every big-values table, with the codebook ROM selected outside and linbits supplied at run time.

---
 rtl/huff_pair_decoder_if.sv | 33 +++
 rtl/huff_pair_decoder.sv | 221 ++++++++++++++++++++++
 tb/tb_huff_pair_decoder.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/huff_pair_decoder_if.sv
// Handshake bundle for the Huffman pair decoder: the serial bit stream in,
// the external codebook lookup port, and the decoded (x, y) pair out.
// The "slave" modport is the decoder's view; "master" is the environment's.
interface huff_pair_decoder_if #(
    parameter int MAX_CODE_BITS = 19,
    parameter int OUT_W         = 16
);
    // serial bit stream
    logic                     axiiv;
    logic                     axiid;
    logic                     axiir;
    // codebook lookup
    logic [MAX_CODE_BITS-1:0] cb_code;
    logic [4:0]               cb_len;
    logic                     cb_hit;
    logic [3:0]               cb_x;
    logic [3:0]               cb_y;
    // decoded pair
    logic                     axiov;
    logic                     axior;
    logic signed [OUT_W-1:0]  x_val;
    logic signed [OUT_W-1:0]  y_val;

    modport slave (
        input  axiiv, axiid, cb_hit, cb_x, cb_y, axior,
        output axiir, cb_code, cb_len, axiov, x_val, y_val
    );

    modport master (
        output axiiv, axiid, cb_hit, cb_x, cb_y, axior,
        input  axiir, cb_code, cb_len, axiov, x_val, y_val
    );
endinterface

// File: rtl/huff_pair_decoder.sv
// Serial Huffman pair decoder for MP3 big-values regions. One bit per cycle:
// resolves the codeword through an external codebook, then reads the optional
// escape (linbits) and sign fields, and presents a signed (x, y) pair.
module huff_pair_decoder #(
    parameter int MAX_CODE_BITS = 19,
    parameter int MAX_LINBITS   = 13,
    parameter int OUT_W         = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic [3:0]         linbits,
    huff_pair_decoder_if.slave bus,
    output logic               err
);
    typedef enum logic [2:0] {
        ST_CODE, ST_XLIN, ST_XSIGN, ST_YLIN, ST_YSIGN, ST_OUT
    } state_t;

    state_t                   state_reg, state_next;
    logic [MAX_CODE_BITS-2:0] buf_reg, buf_next;
    logic [4:0]               count_reg, count_next;
    logic [3:0]               lb_reg, lb_next;
    logic [3:0]               fcnt_reg, fcnt_next;
    logic [3:0]               x_abs_reg, x_abs_next, y_abs_reg, y_abs_next;
    logic [MAX_LINBITS-1:0]   x_lin_reg, x_lin_next, y_lin_reg, y_lin_next;
    logic                     x_neg_reg, x_neg_next, y_neg_reg, y_neg_next;
    logic signed [OUT_W-1:0]  x_val_reg, x_val_next, y_val_reg, y_val_next;
    logic                     err_reg, err_next;
    logic [OUT_W-1:0]         x_mag, y_mag;

    logic       take;
    logic [3:0] sel_x, sel_y, sel_lb;
    logic       x_esc, x_nz, y_esc, y_nz;

    // Returns the first field at or after position 'from' (0=XLIN .. 3=YSIGN)
    // that applies to this pair, or OUT when none remain.
    function automatic state_t next_field(input int from, input logic xe, input logic xn,
                                          input logic ye, input logic yn);
        state_t s;
        s = ST_OUT;
        if (from <= 3 && yn) s = ST_YSIGN;
        if (from <= 2 && ye) s = ST_YLIN;
        if (from <= 1 && xn) s = ST_XSIGN;
        if (from <= 0 && xe) s = ST_XLIN;
        return s;
    endfunction

    assign take      = bus.axiiv && bus.axiir;
    assign bus.axiir = (state_reg != ST_OUT);
    assign bus.axiov = (state_reg == ST_OUT);
    assign bus.x_val = x_val_reg;
    assign bus.y_val = y_val_reg;
    assign err       = err_reg;

    // Candidate codeword is only presented while a bit is on offer in CODE.
    assign bus.cb_len  = (state_reg == ST_CODE && bus.axiiv) ? count_reg + 5'd1 : 5'd0;
    assign bus.cb_code = (state_reg == ST_CODE && bus.axiiv) ? {buf_reg, bus.axiid} : '0;

    // Field applicability: at the hit the codebook magnitudes (and, on the
    // first bit, the live linbits) decide; afterwards the latched copies do.
    assign sel_x  = (state_reg == ST_CODE) ? bus.cb_x : x_abs_reg;
    assign sel_y  = (state_reg == ST_CODE) ? bus.cb_y : y_abs_reg;
    assign sel_lb = (state_reg == ST_CODE && count_reg == 5'd0) ? linbits : lb_reg;
    assign x_esc  = (sel_x == 4'd15) && (sel_lb != 4'd0);
    assign y_esc  = (sel_y == 4'd15) && (sel_lb != 4'd0);
    assign x_nz   = (sel_x != 4'd0);
    assign y_nz   = (sel_y != 4'd0);

    // Next-state and datapath update for each decoding phase.
    always_comb begin
        state_next = state_reg;
        buf_next   = buf_reg;
        count_next = count_reg;
        lb_next    = lb_reg;
        fcnt_next  = fcnt_reg;
        x_abs_next = x_abs_reg;
        y_abs_next = y_abs_reg;
        x_lin_next = x_lin_reg;
        y_lin_next = y_lin_reg;
        x_neg_next = x_neg_reg;
        y_neg_next = y_neg_reg;
        x_val_next = x_val_reg;
        y_val_next = y_val_reg;
        err_next   = 1'b0;
        x_mag      = '0;
        y_mag      = '0;

        case (state_reg)
            ST_CODE: begin
                if (take) begin
                    if (count_reg == 5'd0) lb_next = linbits;
                    if (bus.cb_hit) begin
                        x_abs_next = bus.cb_x;
                        y_abs_next = bus.cb_y;
                        buf_next   = '0;
                        count_next = '0;
                        state_next = next_field(0, x_esc, x_nz, y_esc, y_nz);
                    end else if (count_reg == 5'(MAX_CODE_BITS - 1)) begin
                        // codeword too long: drop it and report
                        buf_next   = '0;
                        count_next = '0;
                        err_next   = 1'b1;
                    end else begin
                        buf_next   = {buf_reg[MAX_CODE_BITS-3:0], bus.axiid};
                        count_next = count_reg + 5'd1;
                    end
                end
            end
            ST_XLIN: begin
                if (take) begin
                    x_lin_next = {x_lin_reg[MAX_LINBITS-2:0], bus.axiid};
                    if (fcnt_reg + 4'd1 == lb_reg) begin
                        fcnt_next  = '0;
                        state_next = next_field(1, x_esc, x_nz, y_esc, y_nz);
                    end else begin
                        fcnt_next = fcnt_reg + 4'd1;
                    end
                end
            end
            ST_XSIGN: begin
                if (take) begin
                    x_neg_next = bus.axiid;
                    state_next = next_field(2, x_esc, x_nz, y_esc, y_nz);
                end
            end
            ST_YLIN: begin
                if (take) begin
                    y_lin_next = {y_lin_reg[MAX_LINBITS-2:0], bus.axiid};
                    if (fcnt_reg + 4'd1 == lb_reg) begin
                        fcnt_next  = '0;
                        state_next = next_field(3, x_esc, x_nz, y_esc, y_nz);
                    end else begin
                        fcnt_next = fcnt_reg + 4'd1;
                    end
                end
            end
            ST_YSIGN: begin
                if (take) begin
                    y_neg_next = bus.axiid;
                    state_next = ST_OUT;
                end
            end
            ST_OUT: begin
                if (bus.axior) begin
                    state_next = ST_CODE;
                    lb_next    = '0;
                    fcnt_next  = '0;
                    x_abs_next = '0;
                    y_abs_next = '0;
                    x_lin_next = '0;
                    y_lin_next = '0;
                    x_neg_next = 1'b0;
                    y_neg_next = 1'b0;
                end
            end
            default: state_next = ST_CODE;
        endcase

        // Output values are captured once, on the transition into OUT.
        x_mag = OUT_W'(x_abs_next) + OUT_W'(x_lin_next);
        y_mag = OUT_W'(y_abs_next) + OUT_W'(y_lin_next);
        if (state_reg != ST_OUT && state_next == ST_OUT) begin
            x_val_next = $signed(x_neg_next ? -x_mag : x_mag);
            y_val_next = $signed(y_neg_next ? -y_mag : y_mag);
        end

        // Abort wins over any bit or accept in the same cycle.
        if (flush) begin
            state_next = ST_CODE;
            buf_next   = '0;
            count_next = '0;
            lb_next    = '0;
            fcnt_next  = '0;
            x_abs_next = '0;
            y_abs_next = '0;
            x_lin_next = '0;
            y_lin_next = '0;
            x_neg_next = 1'b0;
            y_neg_next = 1'b0;
            x_val_next = '0;
            y_val_next = '0;
            err_next   = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_CODE;
            buf_reg   <= '0;
            count_reg <= '0;
            lb_reg    <= '0;
            fcnt_reg  <= '0;
            x_abs_reg <= '0;
            y_abs_reg <= '0;
            x_lin_reg <= '0;
            y_lin_reg <= '0;
            x_neg_reg <= 1'b0;
            y_neg_reg <= 1'b0;
            x_val_reg <= '0;
            y_val_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            buf_reg   <= buf_next;
            count_reg <= count_next;
            lb_reg    <= lb_next;
            fcnt_reg  <= fcnt_next;
            x_abs_reg <= x_abs_next;
            y_abs_reg <= y_abs_next;
            x_lin_reg <= x_lin_next;
            y_lin_reg <= y_lin_next;
            x_neg_reg <= x_neg_next;
            y_neg_reg <= y_neg_next;
            x_val_reg <= x_val_next;
            y_val_reg <= y_val_next;
            err_reg   <= err_next;
        end
    end
endmodule

// File: tb/tb_huff_pair_decoder.sv
// Testbench for huff_pair_decoder: a small codebook, a pair-level reference
// model that builds the bitstream and expected values, and per-scenario tasks.
`timescale 1ns/1ps
module tb_huff_pair_decoder;
    localparam int MCB = 19;
    localparam int MLB = 13;
    localparam int OW  = 16;

    localparam logic [4:0] CW_BITS [4] = '{5'b01111, 5'b01101, 5'b00011, 5'b10101};
    localparam int         CW_LEN  [4] = '{4, 4, 4, 5};
    localparam int         CW_X    [4] = '{0, 0, 15, 1};
    localparam int         CW_Y    [4] = '{0, 1, 15, 2};

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic [3:0] linbits;
    logic       err;

    int checks   = 0;
    int failures = 0;

    bit                   bit_q[$];
    logic signed [OW-1:0] exp_x, exp_y;
    int                   cur_lb;

    huff_pair_decoder_if #(.MAX_CODE_BITS(MCB), .OUT_W(OW)) bus ();

    huff_pair_decoder #(.MAX_CODE_BITS(MCB), .MAX_LINBITS(MLB), .OUT_W(OW)) dut (
        .clk(clk), .rst(rst), .flush(flush), .linbits(linbits), .bus(bus), .err(err)
    );

    always #5 clk = ~clk;

    // Codebook: exact match of length and right-justified code.
    always_comb begin
        bus.cb_hit = 1'b0;
        bus.cb_x   = 4'd0;
        bus.cb_y   = 4'd0;
        for (int i = 0; i < 4; i++) begin
            if (int'(bus.cb_len) == CW_LEN[i] && bus.cb_code == MCB'(CW_BITS[i])) begin
                bus.cb_hit = 1'b1;
                bus.cb_x   = 4'(CW_X[i]);
                bus.cb_y   = 4'(CW_Y[i]);
            end
        end
    end

    // Reference model: bitstream and expected pair for one codeword and fields.
    task automatic build_pair(input int ci, input int lb, input int xl, input int yl,
                              input bit xs, input bit ys);
        logic [4:0] w;
        int xa, ya, xm, ym;
        bit_q.delete();
        w = CW_BITS[ci];
        for (int b = CW_LEN[ci] - 1; b >= 0; b--) bit_q.push_back(w[b]);
        xa = CW_X[ci]; ya = CW_Y[ci]; xm = xa; ym = ya;
        if (xa == 15 && lb != 0) begin
            xm = xa + xl;
            for (int b = lb - 1; b >= 0; b--) bit_q.push_back(((xl >> b) & 1) != 0);
        end
        if (xa != 0) bit_q.push_back(xs);
        if (ya == 15 && lb != 0) begin
            ym = ya + yl;
            for (int b = lb - 1; b >= 0; b--) bit_q.push_back(((yl >> b) & 1) != 0);
        end
        if (ya != 0) bit_q.push_back(ys);
        exp_x  = OW'((xs && xa != 0) ? -xm : xm);
        exp_y  = OW'((ys && ya != 0) ? -ym : ym);
        cur_lb = lb;
    endtask

    // Raw bit driver (no checking), used to park the decoder mid-pair.
    task automatic drive_bits(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.axiiv = 1'b1;
            bus.axiid = bit_q[i];
        end
        @(negedge clk);
        bus.axiiv = 1'b0;
    endtask

    // Feeds the modelled bitstream with random gaps, checks latency, bit count,
    // values, stall behaviour and acceptance.
    task automatic run_pair(input int stall, input int gap_pct, input string name);
        int idx;
        bit last_sent;
        bit done;
        idx = 0; last_sent = 0; done = 0;
        linbits = 4'(cur_lb);
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            @(negedge clk);
            checks++;
            if (err !== 1'b0) begin
                failures++;
                $display("FAIL %s err_quiet err=%b required 0", name, err);
            end
            if (last_sent) begin
                checks++;
                if (bus.axiov !== 1'b1) begin
                    failures++;
                    $display("FAIL %s latency axiov=%b required 1", name, bus.axiov);
                end
                last_sent = 0;
            end
            if (bus.axiov === 1'b1) begin
                bus.axiiv = 1'b0;
                checks++;
                if (idx != bit_q.size()) begin
                    failures++;
                    $display("FAIL %s bits_consumed got=%0d required %0d", name, idx, bit_q.size());
                end
                checks++;
                if (bus.x_val !== exp_x || bus.y_val !== exp_y) begin
                    failures++;
                    $display("FAIL %s pair got=(%0d,%0d) required (%0d,%0d)", name,
                             bus.x_val, bus.y_val, exp_x, exp_y);
                end
                for (int s = 0; s < stall; s++) begin
                    bus.axior = 1'b0;
                    bus.axiiv = 1'($urandom_range(0, 1));
                    bus.axiid = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    checks++;
                    if (bus.axiir !== 1'b0 || bus.axiov !== 1'b1 ||
                        bus.x_val !== exp_x || bus.y_val !== exp_y) begin
                        failures++;
                        $display("FAIL %s stall axiir=%b axiov=%b pair=(%0d,%0d) required 0 1 (%0d,%0d)",
                                 name, bus.axiir, bus.axiov, bus.x_val, bus.y_val, exp_x, exp_y);
                    end
                end
                bus.axiiv = 1'b0;
                bus.axior = 1'b1;
                @(negedge clk);
                bus.axior = 1'b0;
                checks++;
                if (bus.axiov !== 1'b0 || bus.axiir !== 1'b1) begin
                    failures++;
                    $display("FAIL %s accept axiov=%b axiir=%b required 0 1", name, bus.axiov, bus.axiir);
                end
                done = 1;
            end else begin
                checks++;
                if (bus.axiir !== 1'b1) begin
                    failures++;
                    $display("FAIL %s axiir_busy axiir=%b required 1", name, bus.axiir);
                end
                if (idx < bit_q.size() && $urandom_range(0, 99) >= gap_pct) begin
                    bus.axiiv = 1'b1;
                    bus.axiid = bit_q[idx];
                    idx++;
                    if (idx == bit_q.size()) last_sent = 1;
                end else begin
                    bus.axiiv = 1'b0;
                    bus.axiid = 1'($urandom_range(0, 1));
                end
            end
        end
        bus.axiiv = 1'b0;
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL %s timeout no axiov after %0d bits", name, idx);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.axiov !== 1'b0 || err !== 1'b0 || bus.axiir !== 1'b1 || bus.cb_len !== 5'd0 ||
            bus.x_val !== 16'sd0 || bus.y_val !== 16'sd0) begin
            failures++;
            $display("FAIL reset axiov=%b err=%b axiir=%b cb_len=%0d x=%0d y=%0d required 0 0 1 0 0 0",
                     bus.axiov, err, bus.axiir, bus.cb_len, bus.x_val, bus.y_val);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        build_pair(0, 5, 0, 0, 1'b0, 1'b0); run_pair(0, 0, "zero_pair");
        build_pair(1, 5, 0, 0, 1'b0, 1'b1); run_pair(0, 0, "y_sign");
        build_pair(2, 5, 2, 0, 1'b1, 1'b0); run_pair(0, 0, "escape");
        build_pair(2, 0, 0, 0, 1'b0, 1'b1); run_pair(0, 0, "no_linbits");
    endtask

    task automatic test_back_to_back();
        build_pair(1, 5, 0, 0, 1'b0, 1'b1); run_pair(10, 0, "stall10");
        build_pair(3, 5, 0, 0, 1'b0, 1'b0); run_pair(0, 0, "after_stall");
    endtask

    task automatic test_random();
        int ci, lb, xl, yl;
        for (int n = 0; n < 24; n++) begin
            ci = $urandom_range(0, 3);
            lb = $urandom_range(0, MLB);
            xl = (lb != 0) ? $urandom_range(0, (1 << lb) - 1) : 0;
            yl = (lb != 0) ? $urandom_range(0, (1 << lb) - 1) : 0;
            build_pair(ci, lb, xl, yl, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            run_pair($urandom_range(0, 3), 30, "random");
        end
    endtask

    task automatic test_overflow();
        linbits = 4'd5;
        for (int i = 0; i < MCB; i++) begin
            @(negedge clk);
            checks++;
            if (err !== 1'b0 || bus.axiov !== 1'b0) begin
                failures++;
                $display("FAIL overflow_early bit=%0d err=%b axiov=%b required 0 0", i, err, bus.axiov);
            end
            bus.axiiv = 1'b1;
            bus.axiid = 1'b0;
            #1;
            checks++;
            if (bus.cb_len !== 5'(i + 1)) begin
                failures++;
                $display("FAIL overflow_cb_len got=%0d required %0d", bus.cb_len, i + 1);
            end
        end
        @(negedge clk);
        bus.axiiv = 1'b0;
        checks++;
        if (err !== 1'b1 || bus.axiov !== 1'b0) begin
            failures++;
            $display("FAIL overflow_err err=%b axiov=%b required 1 0", err, bus.axiov);
        end
        @(negedge clk);
        checks++;
        if (err !== 1'b0 || bus.axiov !== 1'b0 || bus.cb_len !== 5'd0) begin
            failures++;
            $display("FAIL overflow_pulse err=%b axiov=%b cb_len=%0d required 0 0 0", err, bus.axiov, bus.cb_len);
        end
        build_pair(3, 5, 0, 0, 1'b1, 1'b0); run_pair(0, 0, "after_overflow");
    endtask

    task automatic test_flush();
        build_pair(2, 5, 9, 3, 1'b1, 1'b0);
        linbits = 4'd5;
        drive_bits(6);
        flush     = 1'b1;
        bus.axiiv = 1'b1;
        bus.axiid = 1'b1;
        @(negedge clk);
        flush     = 1'b0;
        bus.axiiv = 1'b0;
        checks++;
        if (bus.axiov !== 1'b0 || bus.axiir !== 1'b1 || err !== 1'b0) begin
            failures++;
            $display("FAIL flush_xlin axiov=%b axiir=%b err=%b required 0 1 0", bus.axiov, bus.axiir, err);
        end
        build_pair(2, 3, 5, 6, 1'b1, 1'b1); run_pair(0, 0, "after_flush");
        // abort a completed pair before it is accepted
        build_pair(2, 3, 5, 6, 1'b1, 1'b1);
        linbits = 4'd3;
        drive_bits(bit_q.size());
        checks++;
        if (bus.axiov !== 1'b1) begin
            failures++;
            $display("FAIL flush_out_ready axiov=%b required 1", bus.axiov);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checks++;
        if (bus.axiov !== 1'b0 || bus.axiir !== 1'b1) begin
            failures++;
            $display("FAIL flush_out axiov=%b axiir=%b required 0 1", bus.axiov, bus.axiir);
        end
        build_pair(3, 5, 0, 0, 1'b1, 1'b1); run_pair(0, 0, "after_flush_out");
    endtask

    task automatic test_rst_mid();
        build_pair(2, 5, 7, 4, 1'b0, 1'b1);
        linbits = 4'd5;
        drive_bits(15);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.axiov !== 1'b0 || err !== 1'b0 || bus.axiir !== 1'b1 || bus.cb_len !== 5'd0 ||
            bus.x_val !== 16'sd0 || bus.y_val !== 16'sd0) begin
            failures++;
            $display("FAIL rst_mid axiov=%b err=%b axiir=%b cb_len=%0d x=%0d y=%0d required 0 0 1 0 0 0",
                     bus.axiov, err, bus.axiir, bus.cb_len, bus.x_val, bus.y_val);
        end
        rst = 1'b0;
        build_pair(2, 5, 7, 4, 1'b0, 1'b1); run_pair(0, 0, "after_rst");
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        linbits   = 4'd0;
        bus.axiiv = 1'b0;
        bus.axiid = 1'b0;
        bus.axior = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_overflow();
        test_flush();
        test_rst_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
